ram_port_master: RTL and testbench

RAM_PORT_MASTER -- requirements
Module: ram_port_master

---
 rtl/ram_port_pkg.sv | 17 +
 rtl/ram_rd_skid.sv | 66 ++++++
 rtl/ram_port_master.sv | 164 ++++++++++++++++
 tb/tb_ram_port_master.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_pkg.sv
// ram_port_pkg
// Shared definitions for the RAM port burst master: FSM state encoding and
// default word/address widths. No ports; imported by ram_port_master and
// ram_rd_skid.
package ram_port_pkg;

   localparam int DATA_DEF = 72;  // memory word width
   localparam int ADDR_DEF = 10;  // memory address width (depth 2**ADDR)

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

endpackage

// File: rtl/ram_rd_skid.sv
// ram_rd_skid
// Two-entry FIFO that buffers read beats (data plus last tag) between the
// registered RAM output and the read-data stream.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   push, push_data/last  write one entry (ignored when full and not popping)
//   pop                   remove head entry (ignored when empty)
//   head_data, head_last  current head entry; head_last is 0 when empty
//   count                 occupancy 0..2
module ram_rd_skid
   import ram_port_pkg::*;
#(
   parameter int DATA = DATA_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic [DATA-1:0] push_data,
   input  logic            push_last,
   input  logic            pop,
   output logic [DATA-1:0] head_data,
   output logic            head_last,
   output logic [1:0]      count
);

   logic [DATA-1:0] data_q [2];
   logic            last_q [2];
   logic            wr_ptr_q;
   logic            rd_ptr_q;
   logic [1:0]      count_q;
   logic            do_push;
   logic            do_pop;

   assign do_pop  = pop && (count_q != 2'd0);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push && ((count_q != 2'd2) || do_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
         last_q[0] <= 1'b0;
         last_q[1] <= 1'b0;
      end else begin
         if (do_push) begin
            data_q[wr_ptr_q] <= push_data;
            last_q[wr_ptr_q] <= push_last;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_data = data_q[rd_ptr_q];
   assign head_last = (count_q != 2'd0) && last_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/ram_port_master.sv
// ram_port_master
// Burst master for a single-port synchronous RAM. Accepts write or read burst
// commands, streams write beats into the RAM and streams read beats out of it
// through a two-entry skid FIFO so read throughput is one beat per cycle.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   cmd_valid/ready, cmd_wr,      burst command: direction, start address,
//   cmd_addr, cmd_len             beats minus one
//   wdata_valid/ready, wdata      write-data stream
//   rdata_valid/ready, rdata,     read-data stream, rdata_last on final beat
//   rdata_last
//   busy, done                    not-IDLE flag, one-cycle completion pulse
//   mem_wr, mem_addr, mem_din,    RAM port; mem_dout is registered and valid
//   mem_dout                      the cycle after the address is presented
//   dbg_state                     current FSM state
//
// Handshakes: every stream transfers a beat on a rising edge where valid and
// ready are both high; valid never waits for ready, and cmd_ready/wdata_ready
// depend only on the FSM state, rdata_valid only on FIFO occupancy.
module ram_port_master
   import ram_port_pkg::*;
#(
   parameter int DATA = DATA_DEF,
   parameter int ADDR = ADDR_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_wr,
   input  logic [ADDR-1:0] cmd_addr,
   input  logic [ADDR-1:0] cmd_len,
   input  logic            wdata_valid,
   output logic            wdata_ready,
   input  logic [DATA-1:0] wdata,
   output logic            rdata_valid,
   input  logic            rdata_ready,
   output logic [DATA-1:0] rdata,
   output logic            rdata_last,
   output logic            busy,
   output logic            done,
   output logic            mem_wr,
   output logic [ADDR-1:0] mem_addr,
   output logic [DATA-1:0] mem_din,
   input  logic [DATA-1:0] mem_dout,
   output state_t          dbg_state
);

   state_t          state_q, state_d;
   logic [ADDR-1:0] addr_q, addr_d;
   logic [ADDR-1:0] cnt_q, cnt_d;
   logic            inflight_q, inflight_d;
   logic            inflight_last_q, inflight_last_d;
   logic            done_q, done_d;

   logic [1:0]      fifo_count;
   logic            fifo_pop;
   logic [2:0]      slots_used;
   logic            issue;

   ram_rd_skid #(.DATA(DATA)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data (mem_dout),
      .push_last (inflight_last_q),
      .pop       (fifo_pop),
      .head_data (rdata),
      .head_last (rdata_last),
      .count     (fifo_count)
   );

   assign rdata_valid = (fifo_count != 2'd0);
   assign fifo_pop    = rdata_valid && rdata_ready;

   // Entries held after this edge: a beat leaving the FIFO now frees its slot
   // for a new read, which keeps a one-beat-per-cycle stream going while
   // never letting buffered plus in-flight reads exceed two.
   assign slots_used = {1'b0, fifo_count} - {2'b00, fifo_pop} + {2'b00, inflight_q};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         addr_q          <= '0;
         cnt_q           <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         cnt_q           <= cnt_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         done_q          <= done_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      cnt_d           = cnt_q;
      done_d          = 1'b0;
      issue           = 1'b0;
      cmd_ready       = 1'b0;
      wdata_ready     = 1'b0;
      mem_wr          = 1'b0;
      mem_din         = '0;

      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               cnt_d   = cmd_len;
               state_d = cmd_wr ? ST_WRITE : ST_READ;
            end
         end
         ST_WRITE: begin
            wdata_ready = 1'b1;
            mem_wr      = wdata_valid;
            mem_din     = wdata;
            if (wdata_valid) begin
               addr_d = addr_q + ADDR'(1);
               if (cnt_q == '0) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q - ADDR'(1);
               end
            end
         end
         ST_READ: begin
            if (slots_used < 3'd2) begin
               issue  = 1'b1;
               addr_d = addr_q + ADDR'(1);
               if (cnt_q == '0) begin
                  state_d = ST_DRAIN;
               end else begin
                  cnt_d = cnt_q - ADDR'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (!inflight_q && (fifo_count == 2'd0)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The in-flight flag lives exactly one cycle: the RAM answers on the next
   // edge and the beat is pushed into the FIFO at that edge.
   assign inflight_d      = issue;
   assign inflight_last_d = issue && (cnt_q == '0);

   assign mem_addr  = addr_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_port_master.sv
module tb_ram_port_master;
   import ram_port_pkg::*;

   localparam int DATA  = 72;
   localparam int ADDR  = 10;
   localparam int DEPTH = 1 << ADDR;
   localparam int W     = DATA + 1;

   logic            clk;
   logic            rst_n;
   logic            cmd_valid;
   logic            cmd_ready;
   logic            cmd_wr;
   logic [ADDR-1:0] cmd_addr;
   logic [ADDR-1:0] cmd_len;
   logic            wdata_valid;
   logic            wdata_ready;
   logic [DATA-1:0] wdata;
   logic            rdata_valid;
   logic            rdata_ready;
   logic [DATA-1:0] rdata;
   logic            rdata_last;
   logic            busy;
   logic            done;
   logic            mem_wr;
   logic [ADDR-1:0] mem_addr;
   logic [DATA-1:0] mem_din;
   logic [DATA-1:0] mem_dout;
   state_t          dbg_state;

   ram_port_master #(.DATA(DATA), .ADDR(ADDR)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_wr      (cmd_wr),
      .cmd_addr    (cmd_addr),
      .cmd_len     (cmd_len),
      .wdata_valid (wdata_valid),
      .wdata_ready (wdata_ready),
      .wdata       (wdata),
      .rdata_valid (rdata_valid),
      .rdata_ready (rdata_ready),
      .rdata       (rdata),
      .rdata_last  (rdata_last),
      .busy        (busy),
      .done        (done),
      .mem_wr      (mem_wr),
      .mem_addr    (mem_addr),
      .mem_din     (mem_din),
      .mem_dout    (mem_dout),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- external synchronous RAM ----------------
   logic [DATA-1:0] ram [DEPTH];
   always @(posedge clk) begin
      if (mem_wr) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
   end

   // ---------------- reference model / scoreboard ----------------
   logic [DATA-1:0] ref_mem [DEPTH];     // expected RAM contents
   logic [ADDR-1:0] exp_wa_q [$];        // expected write addresses in order
   logic [DATA-1:0] exp_wd_q [$];        // expected write data in order
   logic [W-1:0]    exp_q [$];           // expected read beats {last, data}

   int n_tests;
   int n_fail;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DATA-1:0] rand_word();
      return DATA'({$urandom(), $urandom(), $urandom()});
   endfunction

   // Every RAM write is matched against the model's expected write order.
   logic [ADDR-1:0] mon_a;
   logic [DATA-1:0] mon_d;
   always @(negedge clk) begin
      if (rst_n && mem_wr) begin
         if (exp_wa_q.size() == 0) begin
            check("wr_unexpected", W'(1), W'(0));
         end else begin
            mon_a = exp_wa_q.pop_front();
            mon_d = exp_wd_q.pop_front();
            check("wr_addr", W'(mem_addr), W'(mon_a));
            check("wr_data", W'(mem_din), W'(mon_d));
         end
      end
   end

   // ---------------- driver tasks (entered at posedge + 1) ----------------
   task automatic send_cmd(input logic wr, input logic [ADDR-1:0] addr, input logic [ADDR-1:0] len);
      int t;
      cmd_wr    = wr;
      cmd_addr  = addr;
      cmd_len   = len;
      cmd_valid = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!cmd_ready && t < 20);
      check("cmd_accept", W'(cmd_ready), W'(1));
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   // seq=1: data is base+i; otherwise random. stall_pct: chance of idle beat.
   task automatic write_burst(input logic [ADDR-1:0] addr, input int len, input bit seq,
                              input logic [DATA-1:0] base, input int stall_pct, input int init_delay);
      logic [DATA-1:0] wq [$];
      logic [ADDR-1:0] a;
      int i, t, cyc;
      logic acc;
      for (int k = 0; k <= len; k++) begin
         a = ADDR'((int'(addr) + k) % DEPTH);
         wq.push_back(seq ? base + DATA'(k) : rand_word());
         exp_wa_q.push_back(a);
         exp_wd_q.push_back(wq[k]);
         ref_mem[a] = wq[k];
      end
      send_cmd(1'b1, addr, ADDR'(len));
      i = 0; t = 0; cyc = 0;
      while (i <= len && t < 2000) begin
         wdata       = wq[i];
         wdata_valid = (cyc >= init_delay) && (int'($urandom_range(99)) >= stall_pct);
         @(negedge clk);
         if (!wdata_valid) check("wr_stall_no_write", W'(mem_wr), W'(0));
         acc = wdata_valid && wdata_ready;
         @(posedge clk);
         #1;
         if (acc) i++;
         cyc++;
         t++;
      end
      wdata_valid = 1'b0;
      if (t >= 2000) check("wr_timeout", W'(0), W'(1));
      if (stall_pct == 0 && init_delay == 0) check("wr_consecutive", W'(cyc), W'(len + 1));
      @(negedge clk);
      check("wr_done_next_cycle", W'(done), W'(1));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("wr_done_one_cycle", W'(done), W'(0));
      check("wr_idle_after", W'(busy), W'(0));
      check("wr_all_seen", W'(exp_wa_q.size()), W'(0));
      @(posedge clk);
      #1;
   endtask

   // mode 0: rdata_ready held high; 1: ready one cycle in three; 2: random.
   task automatic read_burst(input logic [ADDR-1:0] addr, input int len, input int mode);
      logic [ADDR-1:0] a;
      logic [W-1:0] e;
      int k, beats, first, t, occ;
      for (int j = 0; j <= len; j++) begin
         a = ADDR'((int'(addr) + j) % DEPTH);
         exp_q.push_back({(j == len), ref_mem[a]});
      end
      send_cmd(1'b0, addr, ADDR'(len));
      k = 0; beats = 0; first = -1; t = 0;
      while (beats <= len && t < 2000) begin
         rdata_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 2) : 1'($urandom_range(1));
         @(negedge clk);
         k++;
         occ = int'(u_dut.fifo_count) + int'(u_dut.inflight_q);
         if (mode == 1) check("rd_outstanding_le2", W'(occ <= 2), W'(1));
         if (rdata_valid && first < 0) begin
            first = k;
            // rising edges between the accepting edge and first valid beat
            if (mode == 0) check("rd_first_latency", W'(k - 1), W'(2));
         end else if (mode == 0 && first > 0) begin
            check("rd_streaming", W'(rdata_valid), W'(1));
         end
         if (rdata_valid && rdata_ready) begin
            if (exp_q.size() == 0) begin
               check("rd_extra_beat", W'(1), W'(0));
            end else begin
               e = exp_q.pop_front();
               check("rd_beat", {rdata_last, rdata}, e);
            end
            beats++;
         end
         @(posedge clk);
         #1;
         t++;
      end
      rdata_ready = 1'b0;
      if (t >= 2000) check("rd_timeout", W'(0), W'(1));
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!done && t < 6);
      check("rd_done", W'(done), W'(1));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rd_idle_after", W'(busy), W'(0));
      check("rd_fifo_empty_after", W'(rdata_valid), W'(0));
      @(posedge clk);
      #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < DEPTH; i++) begin
         ram[i]     = '0;
         ref_mem[i] = '0;
      end
      rst_n       = 1'b0;
      cmd_valid   = 1'b0;
      cmd_wr      = 1'b0;
      cmd_addr    = '0;
      cmd_len     = '0;
      wdata_valid = 1'b0;
      wdata       = '0;
      rdata_ready = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_mem_wr", W'(mem_wr), W'(0));
      check("rst_rdata_valid", W'(rdata_valid), W'(0));
      check("rst_rdata_last", W'(rdata_last), W'(0));
      check("rst_busy", W'(busy), W'(0));
      check("rst_done", W'(done), W'(0));
      check("rst_wdata_ready", W'(wdata_ready), W'(0));
      check("rst_state", W'(dbg_state), W'(ST_IDLE));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_cmd_ready", W'(cmd_ready), W'(1));
      @(posedge clk);
      #1;

      // four-beat write then read of 0xA..0xD at 0x010
      write_burst(ADDR'(16), 3, 1'b1, DATA'(10), 0, 0);
      read_burst(ADDR'(16), 3, 0);

      // burst across the top of the address space
      write_burst(ADDR'(1022), 3, 1'b0, '0, 0, 0);
      read_burst(ADDR'(1022), 3, 0);

      // eight beats with stalled writes, read back with sparse rdata_ready
      write_burst(ADDR'(32), 7, 1'b0, '0, 40, 0);
      read_burst(ADDR'(32), 7, 1);

      // single beat with write data arriving five cycles late
      write_burst(ADDR'(200), 0, 1'b1, DATA'(72'h5A5), 0, 5);
      read_burst(ADDR'(200), 0, 0);

      // random traffic
      for (int n = 0; n < 14; n++) begin
         if ($urandom_range(1) == 1)
            write_burst(ADDR'($urandom_range(DEPTH - 1)), int'($urandom_range(15)), 1'b0, '0, 30, 0);
         else
            read_burst(ADDR'($urandom_range(DEPTH - 1)), int'($urandom_range(15)), 2);
      end

      // reset in the middle of a read burst
      send_cmd(1'b0, ADDR'(32), ADDR'(7));
      repeat (3) begin
         @(negedge clk);
      end
      check("mid_rd_buffered", W'(rdata_valid), W'(1));
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("mid_rst_rdata_valid", W'(rdata_valid), W'(0));
      check("mid_rst_busy", W'(busy), W'(0));
      check("mid_rst_done", W'(done), W'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_no_done", W'(done), W'(0));
         check("post_rst_cmd_ready", W'(cmd_ready), W'(1));
      end
      @(posedge clk);
      #1;
      read_burst(ADDR'(16), 3, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
